// File: rtl/grammer_reader.sv
// grammer_reader: four-slot write-addressed buffer drained strictly in order
// through a single valid/ready output register tagged with a load count and phase.
// Ports: clk, reset (async, active high); write side wr_en/wr_addr/wr_data;
// read side rd_ready in, rd_valid/rd_data/rd_addr/rd_cnt/rd_phase out;
// status full/empty/overflow. Optional rd_par output when GRAMMER_READER_PARITY_EN
// is defined (even parity of the word held in the output register).
module grammer_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       rd_addr,
  output logic [7:0]       rd_cnt,
  output logic [1:0]       rd_phase,
  output logic             full,
  output logic             empty,
  output logic             overflow
`ifdef GRAMMER_READER_PARITY_EN
  ,
  output logic             rd_par
`endif
);

  logic [WIDTH-1:0] mem [4];
  logic [3:0]       vld;
  logic [3:0]       vld_nxt;
  logic [1:0]       rd_ptr;
  logic [7:0]       ld_cnt;

  logic             free;
  logic             load;
  logic             hit_ld;
  logic             ovf_set;

  function automatic logic [1:0] phase_of(input logic [7:0] c);
    logic [1:0] p;
    if (c == 8'h00)      p = 2'd0;
    else if (c < 8'h80)  p = 2'd1;
    else if (c < 8'hC0)  p = 2'd2;
    else                 p = 2'd3;
    return p;
  endfunction

  always_comb begin
    free    = !rd_valid || rd_ready;
    load    = free && vld[rd_ptr];
    // a write racing the load of the same slot refills it, not an overwrite
    hit_ld  = load && (wr_addr == rd_ptr);
    ovf_set = wr_en && vld[wr_addr] && !hit_ld;
    vld_nxt = vld;
    if (load)  vld_nxt[rd_ptr]  = 1'b0;
    if (wr_en) vld_nxt[wr_addr] = 1'b1;
  end

  // slot storage carries no reset; the valid bits alone define occupancy
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld      <= '0;
      rd_ptr   <= '0;
      ld_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      vld <= vld_nxt;
      if (load) begin
        rd_ptr <= rd_ptr + 2'd1;
        ld_cnt <= ld_cnt + 8'd1;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      rd_phase <= '0;
    end else if (free) begin
      // no skipping ahead: an empty slot at rd_ptr stalls the drain
      rd_valid <= load;
      if (load) begin
        rd_data  <= mem[rd_ptr];
        rd_addr  <= rd_ptr;
        rd_cnt   <= ld_cnt;
        rd_phase <= phase_of(ld_cnt);
      end
    end
  end

`ifdef GRAMMER_READER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rd_par <= 1'b0;
    else if (free && load) rd_par <= ^mem[rd_ptr];
  end
`endif

  assign full  = &vld;
  assign empty = ~|vld && !rd_valid;

endmodule

// File: tb/tb_grammer_reader.sv
// tb_grammer_reader: directed stimulus with a scoreboard queue;
// a negedge monitor pops and compares every accepted output word.
module tb_grammer_reader;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_cnt;
  logic [1:0]  rd_phase;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef GRAMMER_READER_PARITY_EN
  logic        rd_par;
`endif

  grammer_reader #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr),
    .rd_cnt   (rd_cnt),
    .rd_phase (rd_phase),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef GRAMMER_READER_PARITY_EN
    ,
    .rd_par   (rd_par)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  addr;
    logic [7:0]  cnt;
    logic [1:0]  ph;
    logic        par;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] a,
                      input logic [7:0] c, input logic [1:0] p);
    exp_t e;
    e.data = d;
    e.addr = a;
    e.cnt  = c;
    e.ph   = p;
    e.par  = ^d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", rd_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_data", rd_data, e.data);
        chk("mon_addr", {30'd0, rd_addr}, {30'd0, e.addr});
        chk("mon_cnt", {24'd0, rd_cnt}, {24'd0, e.cnt});
        chk("mon_phase", {30'd0, rd_phase}, {30'd0, e.ph});
`ifdef GRAMMER_READER_PARITY_EN
        chk("mon_par", {31'd0, rd_par}, {31'd0, e.par});
`endif
      end
    end
  end

  // inputs change at posedge+1
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] idx_phase(input int i);
    int c;
    c = i % 256;
    if (c == 0)        return 2'd0;
    else if (c < 128)  return 2'd1;
    else if (c < 192)  return 2'd2;
    else               return 2'd3;
  endfunction

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 32'd0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    do_reset;
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_cnt", {24'd0, rd_cnt}, 32'd0);

    // single word, one-cycle latency
    rd_ready = 1'b1;
    push(32'h0000_000A, 2'd0, 8'h00, 2'd0);
    wr(2'd0, 32'h0000_000A);
    chk("lat_not_yet", {31'd0, rd_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {31'd0, rd_valid}, 32'd1);
    chk("lat_data", rd_data, 32'h0000_000A);
    chk("lat_empty", {31'd0, empty}, 32'd0);
    drain("single", 10);

    // fill all four, hold, then release
    do_reset;
    push(32'd1, 2'd0, 8'd0, 2'd0);
    push(32'd2, 2'd1, 8'd1, 2'd1);
    push(32'd3, 2'd2, 8'd2, 2'd1);
    push(32'd4, 2'd3, 8'd3, 2'd1);
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd4);
    wr(2'd0, 32'd1);
    chk("fill_full", {31'd0, full}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", {31'd0, rd_valid}, 32'd1);
    chk("hold_data", rd_data, 32'd1);
    chk("hold_cnt", {24'd0, rd_cnt}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_data2", rd_data, 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_valid", {31'd0, rd_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    chk("burst_empty", {31'd0, empty}, 32'd1);
    drain("burst", 4);

    // in-order stall on a hole at the pointer
    do_reset;
    rd_ready = 1'b1;
    wr(2'd1, 32'h0000_0011);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid", {31'd0, rd_valid}, 32'd0);
    chk("stall_empty", {31'd0, empty}, 32'd0);
    push(32'h0000_0010, 2'd0, 8'd0, 2'd0);
    push(32'h0000_0011, 2'd1, 8'd1, 2'd1);
    wr(2'd0, 32'h0000_0010);
    drain("stall", 10);

    // 260-word round-robin stream: phase bands and count wrap
    do_reset;
    rd_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      push(32'h1000_0000 + i, 2'(i % 4), 8'(i % 256), idx_phase(i));
      wr(2'(i % 4), 32'h1000_0000 + i);
    end
    drain("stream", 20);
    chk("stream_ovf", {31'd0, overflow}, 32'd0);
    chk("stream_empty", {31'd0, empty}, 32'd1);

    // simultaneous write and load of the same slot
    do_reset;
    push(32'h20, 2'd0, 8'd0, 2'd0);
    push(32'h21, 2'd1, 8'd1, 2'd1);
    push(32'h22, 2'd2, 8'd2, 2'd1);
    push(32'h23, 2'd3, 8'd3, 2'd1);
    push(32'h24, 2'd0, 8'd4, 2'd1);
    push(32'h31, 2'd1, 8'd5, 2'd1);
    wr(2'd0, 32'h20);
    wr(2'd1, 32'h21);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wr(2'd1, 32'h31);
    chk("race_ovf", {31'd0, overflow}, 32'd0);
    chk("race_data", rd_data, 32'h21);
    wr(2'd2, 32'h22);
    wr(2'd3, 32'h23);
    wr(2'd0, 32'h24);
    drain("race", 20);
    chk("race_ovf_end", {31'd0, overflow}, 32'd0);

    // overwrite sets sticky overflow, reset clears everything
    do_reset;
    push(32'h100, 2'd0, 8'd0, 2'd0);
    push(32'h101, 2'd1, 8'd1, 2'd1);
    push(32'hDEAD_BEEF, 2'd2, 8'd2, 2'd1);
    push(32'h103, 2'd3, 8'd3, 2'd1);
    wr(2'd0, 32'h100);
    wr(2'd1, 32'h101);
    wr(2'd2, 32'h102);
    wr(2'd3, 32'h103);
    chk("ovf_pre", {31'd0, overflow}, 32'd0);
    wr(2'd2, 32'hDEAD_BEEF);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    rd_ready = 1'b1;
    drain("ovf", 10);
    chk("ovf_after", {31'd0, overflow}, 32'd1);
    rd_ready = 1'b0;
    wr(2'd0, 32'h55);
    @(posedge clk);
    #1;
    chk("inflight_valid", {31'd0, rd_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_ovf", {31'd0, overflow}, 32'd0);
    chk("async_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_empty", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    // first load after reset starts the count over
    rd_ready = 1'b1;
    push(32'h77, 2'd0, 8'd0, 2'd0);
    wr(2'd0, 32'h77);
    drain("post_rst", 10);

`ifdef GRAMMER_READER_PARITY_EN
    do_reset;
    rd_ready = 1'b1;
    push(32'h7, 2'd0, 8'd0, 2'd0);
    push(32'h3, 2'd1, 8'd1, 2'd1);
    wr(2'd0, 32'h7);
    wr(2'd1, 32'h3);
    chk("par_7", {31'd0, rd_par}, 32'd1);
    @(posedge clk);
    #1;
    chk("par_3", {31'd0, rd_par}, 32'd0);
    drain("par", 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grammer_reader.md
GRAMMER_READER -- requirements
Module: grammer_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data word width of every slot and of rd_data.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port wr_en, input, 1, which writes wr_data into slot wr_addr at the clock edge.
REQ-005 SHALL have port wr_addr, input, 2, the slot index 0..3.
REQ-006 SHALL have port wr_data, input, WIDTH, the write payload.
REQ-007 SHALL have port rd_ready, input, 1, consumer accept.
REQ-008 SHALL have port rd_valid, output, 1, meaning the output stage holds a word.
REQ-009 SHALL have port rd_data, output, WIDTH, the output word.
REQ-010 SHALL have port rd_addr, output, 2, the slot the output word came from.
REQ-011 SHALL have port rd_cnt, output, 8, the sequence number of the output word.
REQ-012 SHALL have port rd_phase, output, 2, the phase tag of the output word.
REQ-013 SHALL have port full, output, 1, high when all four slots are valid.
REQ-014 SHALL have port empty, output, 1, high when no slot is valid and rd_valid=0.
REQ-015 SHALL have port overflow, output, 1, a sticky overwrite error flag.

Function
REQ-016 SHALL hold a 4-entry WIDTH-bit slot memory with a per-slot valid bit, a 2-bit read pointer rd_ptr, and an 8-bit load counter ld_cnt.
REQ-017 On wr_en, SHALL store wr_data in slot wr_addr and set its valid bit at the same edge.
REQ-018 SHALL treat the output stage as free when rd_valid=0 or (rd_valid and rd_ready) -- the handshake.
REQ-019 When the output stage is free and valid[rd_ptr]=1, SHALL on the next edge: load rd_data=mem[rd_ptr], rd_addr=rd_ptr, rd_cnt=ld_cnt, rd_phase=phase(ld_cnt); clear valid[rd_ptr]; increment rd_ptr (3 wraps to 0) and ld_cnt (0xFF wraps to 0x00); set rd_valid=1.
REQ-020 When the output stage is free and valid[rd_ptr]=0, SHALL clear rd_valid, leave rd_ptr unchanged, and never skip to a later valid slot (strict in-order drain).
REQ-021 SHALL define phase(c) as: 0 if c==0x00, 1 if c<0x80, 2 if c<0xC0, 3 otherwise (unsigned compare).
REQ-022 While rd_valid=1 and rd_ready=0, SHALL hold rd_data, rd_addr, rd_cnt and rd_phase stable.
REQ-023 Latency: a write to slot rd_ptr at edge N with the stage free SHALL give rd_valid=1 with that data after edge N+1.
REQ-024 A write to a slot whose valid bit is 1 and which is not being loaded at that same edge SHALL overwrite the data and set overflow, which stays 1 until reset.
REQ-025 On a simultaneous write and load of the same slot, SHALL load the old data, leave the slot valid with the new data, and not set overflow.
REQ-026 SHALL derive full and empty from registered state only (no combinational path from inputs).

Reset
REQ-027 While reset=1, SHALL asynchronously clear all valid bits, rd_ptr, ld_cnt, rd_valid, rd_data, rd_addr, rd_cnt, rd_phase and overflow to 0, giving empty=1 and full=0.
REQ-028 Reset mid-operation SHALL discard all stored and in-flight words; slot memory contents need not be cleared.
REQ-029 The first load after reset SHALL carry rd_cnt=0x00, rd_phase=0, rd_addr=0.

Configuration
REQ-030 With macro GRAMMER_READER_PARITY_EN defined, SHALL add output rd_par (1 bit), loaded with the even parity (XOR reduction) of the loaded word under the same rules as rd_data, and reset to 0.
REQ-031 Without GRAMMER_READER_PARITY_EN, the rd_par port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then write 0x0000_000A to slot 0 with rd_ready=1 -> one cycle later rd_valid=1, rd_data=0x0000_000A, rd_addr=0, rd_cnt=0x00, rd_phase=0, empty=0.
REQ-033 Write slots 0..3 with 1,2,3,4 and hold rd_ready=0 -> full=1, slot 0 word held stable; then raise rd_ready -> words 1,2,3,4 emitted on consecutive cycles with rd_cnt 0..3, then empty=1.
REQ-034 Write slot 1 only after reset -> rd_valid stays 0 (pointer at 0); then write slot 0 -> slot 0 word emitted, then slot 1 word.
REQ-035 Stream 200 words round-robin with rd_ready=1 -> rd_phase=0 for word 0, 1 for words 1..127, 2 for words 128..191, 3 for words 192..199, and rd_cnt wraps 0xFF->0x00 after word 255 when extended to 260 words.
REQ-036 Fill all slots, rd_ready=0, write slot 2 with 0xDEAD_BEEF -> overflow=1 and stays 1; slot 2 emits 0xDEAD_BEEF; assert reset -> overflow=0, rd_valid=0, empty=1.
REQ-037 With GRAMMER_READER_PARITY_EN defined, emit 0x0000_0007 -> rd_par=1; emit 0x0000_0003 -> rd_par=0.
